// File: rtl/datapath_sequencer.sv
// Control sequencer for a small accumulate datapath: LOADA, XFER, then N ADD/WB passes, then DONE.
// All control outputs are a Moore decode of the state register.
module datapath_sequencer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] iter,
  output logic             busy,
  output logic             done,
  output logic [2:0]       step,
  output logic             RAin,
  output logic             RBin,
  output logic             RZin,
  output logic             RAout,
  output logic             RBout,
  output logic             RZout
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoadA = 3'd1,
    StXfer  = 3'd2,
    StAdd   = 3'd3,
    StWb    = 3'd4,
    StDone  = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    RAin    = 1'b0;
    RBin    = 1'b0;
    RZin    = 1'b0;
    RAout   = 1'b0;
    RBout   = 1'b0;
    RZout   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StLoadA;
          cnt_d   = iter;
        end
      end
      StLoadA: begin
        RAin    = 1'b1;
        state_d = StXfer;
      end
      StXfer: begin
        RAout   = 1'b1;
        RBin    = 1'b1;
        state_d = (cnt_q != '0) ? StAdd : StDone;
      end
      StAdd: begin
        RBout   = 1'b1;
        RZin    = 1'b1;
        state_d = StWb;
      end
      StWb: begin
        RZout   = 1'b1;
        RBin    = 1'b1;
        // Saturate at zero; cnt_q is never zero here on a legal path anyway.
        if (cnt_q != '0) cnt_d = cnt_q - CntOne;
        state_d = (cnt_q > CntOne) ? StAdd : StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Abort overrides every other transition out of a running sequence.
    if (abort && (state_q != StIdle)) state_d = StIdle;
  end

  assign busy = (state_q != StIdle);
  assign step = state_q;

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 The module SHALL have parameter CNT_W, default 4, meaning the width of the accumulate-pass count.
REQ-002 Port clock: input, 1 bit, single clock; all state changes on its rising edge.
REQ-003 Port clear: input, 1 bit, asynchronous active-low reset.
REQ-004 Port start: input, 1 bit, request to run one sequence; sampled only in IDLE.
REQ-005 Port abort: input, 1 bit, synchronous cancel of a running sequence.
REQ-006 Port iter: input, CNT_W bits, number of add/write-back passes; captured with start.
REQ-007 Port busy: output, 1 bit, high whenever the state is not IDLE.
REQ-008 Port done: output, 1 bit, one-cycle completion pulse.
REQ-009 Port step: output, 3 bits, current state code for debug.
REQ-010 Ports RAin, RBin, RZin: outputs, 1 bit each, register load enables to the datapath.
REQ-011 Ports RAout, RBout, RZout: outputs, 1 bit each, bus drive selects to the datapath.

Function
REQ-012 The state register SHALL hold one of IDLE=0, LOADA=1, XFER=2, ADD=3, WB=4, DONE=5; codes 6-7 SHALL transition to IDLE on the next edge with all controls low.
REQ-013 All control outputs and done SHALL be a Moore decode of the state register only, with no combinational path from inputs.
REQ-014 IDLE: all controls low; if start=1 at the edge, go to LOADA and load cnt<=iter; otherwise stay.
REQ-015 LOADA: RAin=1; next state XFER.
REQ-016 XFER: RAout=1, RBin=1 (RB<=RA); next state ADD if cnt!=0, else DONE.
REQ-017 ADD: RBout=1, RZin=1 (RZ<=A+RB); next state WB.
REQ-018 WB: RZout=1, RBin=1 (RB<=RZ); cnt<=cnt-1; next state ADD if cnt-1!=0, else DONE.
REQ-019 DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
REQ-020 Latency: with start sampled at edge E0 and iter=N, done SHALL be high in the cycle following edge E0+2N+2; for N=0 it follows edge E0+2.
REQ-021 At most one of RAout, RBout, RZout SHALL be high in any cycle.
REQ-022 RBin and RZin SHALL never be high in the same cycle.
REQ-023 start in any state other than IDLE SHALL be ignored; iter changes after capture SHALL have no effect.
REQ-024 start high in DONE SHALL NOT be accepted; a new sequence begins only if start is high at an edge while in IDLE.
REQ-025 abort=1 at an edge in any non-IDLE state SHALL force IDLE on that edge with no done pulse; abort has priority over every other transition.
REQ-026 abort=1 in IDLE with start=1 SHALL leave the state in IDLE.
REQ-027 cnt SHALL be CNT_W bits wide and never decrement below 0; iter=2^CNT_W-1 SHALL perform exactly 2^CNT_W-1 passes.
REQ-028 step SHALL equal the state code; busy SHALL be 1 in states 1-5.

Reset
REQ-029 clear=0 SHALL immediately, without a clock edge, force state=IDLE and cnt=0, driving busy, done, and all six controls low.
REQ-030 clear asserted mid-sequence SHALL abandon the sequence with no done pulse; after release, the first accepted start SHALL begin a clean LOADA.
REQ-031 No start SHALL be accepted on the edge at which clear deasserts if clear is still low at that edge.

Verification
REQ-032 iter=1, start pulsed once -> step sequence 1,2,3,4,5,0; done high for one cycle 4 edges after the start edge; the controls in each cycle match REQ-015 to REQ-019.
REQ-033 iter=0 -> step sequence 1,2,5,0; RZin is never asserted; done 2 edges after the start edge.
REQ-034 iter=3, with iter changed to 7 and start held high during the run -> exactly 3 ADD/WB pairs, done at edge E0+8, and no restart from the held start.
REQ-035 iter=15, abort asserted in the second WB -> state IDLE after that edge, done never high, controls low.
REQ-036 clear pulsed low during ADD -> outputs are low before the next edge; after release, start with iter=2 gives done at E0+6.
REQ-037 Every test SHALL continuously check the one-hot bus drive invariant (REQ-021) and the RBin/RZin exclusion (REQ-022).
